// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage. It issues word reads over req/ack and holds the returned word for decode.
// Define IF_PERF_COUNTERS_EN to add the FetchCount/StallCount performance counter outputs.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0040_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectPC,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemAck,
  input  logic [31:0]           MemRData,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  output logic [31:0]           Instruction,
  output logic [5:0]            OP,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PCPlus4,
  output logic [1:0]            state_dbg
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0]           FetchCount,
  output logic [31:0]           StallCount
`endif
);

  // Handshakes:
  //   memory side: MemReq/MemAddr stay stable until MemAck is seen, and only one
  //     read is outstanding. MemRData is taken in the same cycle as MemAck.
  //   decode side: Instruction/PC/PCPlus4/OP stay stable while InstrValid=1 and
  //     InstrReady=0. A transfer happens on a cycle with InstrValid & InstrReady.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]           instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] target;

  assign target = {RedirectPC[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      pending_q  <= RESET_PC;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + WORD_STEP;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      pending_q  <= pending_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    pending_d  = pending_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (Redirect) begin
          fetch_pc_d = target;
          mem_addr_d = target;
        end else begin
          mem_addr_d = fetch_pc_q;
        end
      end
      S_FETCH: begin
        if (Redirect) begin
          if (MemAck) begin
            fetch_pc_d = target;
            mem_addr_d = target;
          end else begin
            // The read in flight cannot be withdrawn; its data is dropped on arrival.
            pending_d = target;
            state_d   = S_DROP;
          end
        end else if (MemAck) begin
          instr_d    = MemRData;
          pc_d       = mem_addr_q;
          pc_plus4_d = mem_addr_q + WORD_STEP;
          fetch_pc_d = mem_addr_q + WORD_STEP;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          valid_d    = 1'b0;
          fetch_pc_d = target;
          mem_addr_d = target;
          state_d    = S_FETCH;
        end else if (InstrReady) begin
          valid_d    = 1'b0;
          mem_addr_d = fetch_pc_q;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        if (Redirect) begin
          pending_d = target;
        end
        if (MemAck) begin
          // A redirect arriving together with the ack supersedes the stored target.
          mem_addr_d = Redirect ? target : pending_q;
          fetch_pc_d = Redirect ? target : pending_q;
          state_d    = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign MemReq      = (state_q == S_FETCH) || (state_q == S_DROP);
  assign MemAddr     = mem_addr_q;
  assign InstrValid  = valid_q;
  assign Instruction = instr_q;
  assign OP          = instr_q[31:26];
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4_q;
  assign state_dbg   = state_q;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (valid_q && InstrReady) fetch_count_d = fetch_count_q + 32'd1;
    if (valid_q && !InstrReady) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign FetchCount = fetch_count_q;
  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios followed by randomized redirects, ready and memory latency.
// The reference model tracks the next instruction address that decode must receive.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  state_dbg;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [1:0]  w_state;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_count;
  logic [31:0] w_fetch_count, w_stall_count;
`endif

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(RST_PC)) u_dut (
    .clk(clk), .reset(reset), .Redirect(redirect), .RedirectPC(redirect_pc),
    .MemReq(mem_req), .MemAddr(mem_addr), .MemAck(mem_ack), .MemRData(mem_rdata),
    .InstrValid(instr_valid), .InstrReady(instr_ready), .Instruction(instruction),
    .OP(op), .PC(pc), .PCPlus4(pc_plus4), .state_dbg(state_dbg)
`ifdef IF_PERF_COUNTERS_EN
    , .FetchCount(fetch_count), .StallCount(stall_count)
`endif
  );

  // Second instance starts just below the top of the address space; zero-wait memory.
  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .Redirect(1'b0), .RedirectPC(32'h0),
    .MemReq(w_req), .MemAddr(w_addr), .MemAck(w_req), .MemRData(32'h0),
    .InstrValid(w_valid), .InstrReady(1'b1), .Instruction(w_instr),
    .OP(w_op), .PC(w_pc), .PCPlus4(w_pc4), .state_dbg(w_state)
`ifdef IF_PERF_COUNTERS_EN
    , .FetchCount(w_fetch_count), .StallCount(w_stall_count)
`endif
  );

  int          compared;
  int          mismatched;
  logic [31:0] exp_pc;
  int          wait_cnt;
  int          mem_lat;
  bit          rand_lat;
  bit          prev_req_wait;
  logic [31:0] prev_addr;
  bit          prev_hold;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  int          n_acc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_000A;
    if (a == 32'h0040_0004) return 32'h3508_00FF;
    return {a[7:2], a[27:2]} ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc        = RST_PC;
    wait_cnt      = 0;
    prev_req_wait = 1'b0;
    prev_hold     = 1'b0;
    fetch_cnt     = 32'h0;
    stall_cnt     = 32'h0;
  endtask

  // One clock cycle: drive inputs, answer memory, check against the model, advance.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy);
    logic [31:0] w;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    mem_ack     = 1'b0;
    mem_rdata   = $urandom;
    if (mem_req) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end
    if (prev_req_wait) begin
      chk("req_held", {31'b0, mem_req}, 32'h1);
      chk("addr_held", mem_addr, prev_addr);
    end
    if (prev_hold) begin
      chk("valid_held", {31'b0, instr_valid}, 32'h1);
      chk("instr_held", instruction, prev_instr);
      chk("pc_held", pc, prev_pc);
    end
    if (instr_valid) begin
      w = mem_word(exp_pc);
      chk("pc", pc, exp_pc);
      chk("instr", instruction, w);
      chk("op", {26'b0, op}, {26'b0, w[31:26]});
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      if (rdy) begin
        fetch_cnt++;
        n_acc++;
      end else begin
        stall_cnt++;
      end
    end
    prev_req_wait = mem_req && !mem_ack;
    prev_addr     = mem_addr;
    prev_hold     = instr_valid && !rdy && !rd;
    prev_instr    = instruction;
    prev_pc       = pc;
    if (rd) exp_pc = {rpc[31:2], 2'b00};
    else if (instr_valid && rdy) exp_pc = exp_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    n_acc       = 0;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    mem_lat     = 0;
    rand_lat    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_op", {26'b0, op}, 32'h0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc4", pc_plus4, RST_PC + 32'd4);
    chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("rst_wrap_pc4", w_pc4, 32'h0);
    reset = 1'b1;

    // Zero-wait fetch of two words with decode always ready.
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_req0", {31'b0, mem_req}, 32'h1);
    chk("t1_addr0", mem_addr, 32'h0040_0000);
    chk("t1_valid_lo0", {31'b0, instr_valid}, 32'h0);
    chk("t5_addr0", w_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_valid0", {31'b0, instr_valid}, 32'h1);
    chk("t1_op0", {26'b0, op}, 32'h08);
    chk("t1_pc0", pc, 32'h0040_0000);
    chk("t5_pc", w_pc, 32'hFFFF_FFFC);
    chk("t5_pc4", w_pc4, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_valid_lo1", {31'b0, instr_valid}, 32'h0);
    chk("t1_addr1", mem_addr, 32'h0040_0004);
    chk("t5_addr1", w_addr, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_valid1", {31'b0, instr_valid}, 32'h1);
    chk("t1_op1", {26'b0, op}, 32'h0D);
    chk("t1_pc1", pc, 32'h0040_0004);

    // Decode stalls for five cycles.
    repeat (5) begin
      cycle(1'b0, 32'h0, 1'b0);
      chk("t2_req", {31'b0, mem_req}, 32'h0);
      chk("t2_pc", pc, 32'h0040_0004);
      chk("t2_instr", instruction, 32'h3508_00FF);
      chk("t2_op", {26'b0, op}, 32'h0D);
    end
    cycle(1'b0, 32'h0, 1'b1);
    chk("t2_next_addr", mem_addr, 32'h0040_0008);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t2_valid", {31'b0, instr_valid}, 32'h1);

    // Redirect while holding an instruction; low address bits are ignored.
    cycle(1'b1, 32'h0040_0043, 1'b0);
    chk("t3_valid", {31'b0, instr_valid}, 32'h0);
    chk("t3_addr", mem_addr, 32'h0040_0040);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t3_pc", pc, 32'h0040_0040);

    // Redirect during a slow fetch: the old read completes and is dropped.
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_addr_old", mem_addr, 32'h0040_0044);
    mem_lat = 3;
    cycle(1'b1, 32'h0040_0080, 1'b1);
    chk("t4_req", {31'b0, mem_req}, 32'h1);
    chk("t4_addr_hold", mem_addr, 32'h0040_0044);
    repeat (2) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk("t4_addr_wait", mem_addr, 32'h0040_0044);
      chk("t4_valid_lo", {31'b0, instr_valid}, 32'h0);
    end
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_addr_new", mem_addr, 32'h0040_0080);
    chk("t4_valid_drop", {31'b0, instr_valid}, 32'h0);
    mem_lat = 0;
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_pc", pc, 32'h0040_0080);

    // Asynchronous reset while a dropped read is outstanding.
    cycle(1'b0, 32'h0, 1'b1);
    mem_lat = 3;
    cycle(1'b1, 32'h0040_0100, 1'b1);
    chk("t6_req_pre", {31'b0, mem_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req", {31'b0, mem_req}, 32'h0);
    chk("t6_valid", {31'b0, instr_valid}, 32'h0);
    chk("t6_pc", pc, RST_PC);
    chk("t6_instr", instruction, 32'h0);
    model_reset();
    mem_lat = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    chk("t6_first_addr", mem_addr, RST_PC);
    chk("t6_first_req", {31'b0, mem_req}, 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t6_first_valid", {31'b0, instr_valid}, 32'h1);

    // Randomized redirects, decode back-pressure and memory latency.
    rand_lat = 1'b1;
    n_acc    = 0;
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) == 0, 32'h0040_0000 + 32'($urandom_range(0, 1023)),
            $urandom_range(0, 3) != 0);
    end
    chk("rand_progress", {31'b0, (n_acc > 20)}, 32'h1);

`ifdef IF_PERF_COUNTERS_EN
    chk("fetch_count", fetch_count, fetch_cnt);
    chk("stall_count", stall_count, stall_cnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Instruction fetch stage of the MIPS datapath, directly upstream of the control unit and decode.
- Holds the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Captures each returned word into an output register and presents it to decode with a valid/ready handshake.
- Drives the 6-bit opcode field straight into the control unit's OP input.
- Accepts redirects from branch/jump resolution and discards any fetch that the redirect makes stale.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset (MIPS text segment base)
ADDR_WIDTH, 32, PC and memory address width; instruction width is fixed at 32

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Redirect  input  1  one-cycle pulse: restart fetch at RedirectPC
RedirectPC  input  ADDR_WIDTH  redirect target; bits [1:0] are ignored and forced to 00
MemReq  output  1  instruction memory read request
MemAddr  output  ADDR_WIDTH  word address of the current request
MemAck  input  1  read complete; MemRData is valid in the same cycle
MemRData  input  32  instruction word
InstrValid  output  1  Instruction, PC, PCPlus4 and OP are valid
InstrReady  input  1  decode accepts the held instruction
Instruction  output  32  held instruction word
OP  output  6  Instruction[31:26]; feeds the control unit's OP input
PC  output  ADDR_WIDTH  address of the held instruction
PCPlus4  output  ADDR_WIDTH  PC+4, modulo 2^ADDR_WIDTH

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, InstrValid=0, Instruction=0, PC=RESET_PC, PCPlus4=RESET_PC+4, MemReq=0.
  - OP=0 decodes as R-type, so consumers must gate on InstrValid.
- States: IDLE, FETCH, HOLD, DROP. MemReq=1 in FETCH and DROP, 0 otherwise. MemAddr is registered.
- IDLE -> FETCH unconditionally on the first clock edge after reset release. MemAddr=fetch_pc.
- FETCH (no Redirect):
  - MemAck=0: stay in FETCH. MemReq and MemAddr are held stable.
  - MemAck=1: on the next edge, Instruction<=MemRData, PC<=MemAddr, PCPlus4<=MemAddr+4, fetch_pc<=MemAddr+4, InstrValid<=1, state -> HOLD.
- HOLD: MemReq=0. Instruction, PC and OP are held stable while InstrReady=0.
  - InstrReady=1: InstrValid<=0, state -> FETCH, MemAddr<=fetch_pc.
  - Minimum latency: request to InstrValid is 1 cycle with zero-wait memory. Throughput is 1 instruction per 2 cycles.
- Redirect has priority over every other event. target = {RedirectPC[ADDR_WIDTH-1:2],2'b00}.
  - In HOLD (with or without InstrReady): InstrValid<=0, fetch_pc<=target, state -> FETCH.
  - In FETCH with MemAck=1 in the same cycle: returned data is discarded, InstrValid stays 0, next MemAddr=target, state stays FETCH.
  - In FETCH with MemAck=0: the request cannot be withdrawn. MemReq and MemAddr hold the old address. pending target is stored, state -> DROP.
  - In DROP: on MemAck=1 the data is discarded, MemAddr<=pending target, state -> FETCH.
  - A further Redirect in DROP overwrites the pending target; the last one wins.
  - In IDLE: fetch_pc<=target, state -> FETCH.
- Only one memory request is outstanding at a time. InstrValid is never asserted for discarded data.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Async reset asserted mid-request or mid-HOLD: all outputs go to their reset values immediately. Any in-flight MemAck is ignored.

Optional Feature:
IF_PERF_COUNTERS_EN
- Defined: adds two 32-bit outputs.
  - FetchCount: increments each cycle InstrValid&InstrReady.
  - StallCount: increments each cycle InstrValid&!InstrReady.
  - Both reset to 0, wrap at 2^32, and are cleared by reset only.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
1. Release reset, zero-wait memory returning 32'h2008_000A then 32'h3508_00FF, InstrReady=1 -> MemAddr 0x00400000 then 0x00400004; OP=0x08 then 0x0D; PC=0x00400000 then 0x00400004; InstrValid high every 2nd cycle.
2. InstrReady=0 for 5 cycles in HOLD -> Instruction, PC and OP stable, MemReq=0 throughout; after InstrReady=1 the next MemAddr is PC+4.
3. Redirect=1 with RedirectPC=0x00400043 in HOLD -> InstrValid=0 next cycle; next MemAddr=0x00400040.
4. Redirect to 0x00400080 during FETCH, with MemAck delayed 3 cycles -> MemAddr holds the old address until ack, InstrValid never rises for that data, next MemAddr=0x00400080.
5. RESET_PC=32'hFFFF_FFFC, zero-wait memory, InstrReady=1 -> second MemAddr=0x00000000; PCPlus4 of the first instruction=0x00000000.
6. Drop reset asynchronously between clock edges during DROP with MemReq=1 -> MemReq=0, InstrValid=0, PC=RESET_PC immediately; after release the first request goes to RESET_PC.
